// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_pkg : shared types and encodings for the RV32M divide group   |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package muldiv_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;

    // Special-case results for the default width; the top re-derives them for its own WIDTH.
    localparam logic [DIV_WIDTH-1:0] DIV_MIN_INT  = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    localparam logic [DIV_WIDTH-1:0] DIV_ALL_ONES = {DIV_WIDTH{1'b1}};

endpackage
`default_nettype wire

// File: rtl/div_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_sequencer_if : request/result bundle between core and divider    |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [2:0]       funct3_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             flush_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, funct3_i, a_i, b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, a_i, b_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_step : one combinational radix-2 restoring division iteration    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   rem_next,
    output logic             q_bit
);
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH+1:0] w_trial;
    logic             w_unused_rem_msb;

    // The partial remainder is always below the divisor, so its top bit never carries data.
    assign w_unused_rem_msb = rem[WIDTH];
    assign w_shifted        = {rem[WIDTH-1:0], dvd_msb};
    assign w_trial          = {1'b0, w_shifted} - {2'b00, dvs};
    assign q_bit            = ~w_trial[WIDTH+1];
    assign rem_next         = q_bit ? w_trial[WIDTH:0] : w_shifted;
endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_sequencer : multi-cycle DIV/DIVU/REM/REMU sequencer              |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module div_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    div_sequencer_if.slave   bus
);
    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_min_int  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};

    div_state_t       r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_count;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;

    logic             w_unused_funct3;
    logic             w_div_zero;
    logic             w_overflow;
    logic             w_special;
    logic [WIDTH-1:0] w_special_result;
    logic             w_signed;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_next;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_unused_funct3 = bus.funct3_i[2];

    // Special cases are judged on the raw request operands, before anything is latched.
    assign w_div_zero = (bus.b_i == '0);
    assign w_overflow = ~bus.funct3_i[0] & (bus.a_i == c_min_int) & (bus.b_i == c_all_ones);
    assign w_special  = w_div_zero | w_overflow;
    assign w_special_result = w_div_zero ? (bus.funct3_i[1] ? bus.a_i : c_all_ones)
                                         : (bus.funct3_i[1] ? '0      : c_min_int);

    assign w_signed  = (r_op == DIV_OP) || (r_op == REM_OP);
    assign w_abs_a   = (w_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_abs_b   = (w_signed && r_b[WIDTH-1]) ? -r_b : r_b;
    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r_rem),
        .dvd_msb  (r_dvd[WIDTH-1]),
        .dvs      (r_dvs),
        .rem_next (w_rem_next),
        .q_bit    (w_q_bit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_count  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.flush_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                    r_state <= S_IDLE;
                    if (bus.start_i) begin
                        r_op <= bus.funct3_i[1:0];
                        r_a  <= bus.a_i;
                        r_b  <= bus.b_i;
                        if (w_special) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= w_special_result;
                        end else begin
                            r_state <= S_PREP;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_PREP: begin
                    r_dvd   <= w_abs_a;
                    r_dvs   <= w_abs_b;
                    r_rem   <= '0;
                    r_quo   <= '0;
                    r_count <= '0;
                    r_neg_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_neg_r <= w_signed & r_a[WIDTH-1];
                    r_state <= S_ITER;
                end
                S_ITER: begin
                    r_rem   <= w_rem_next;
                    r_dvd   <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_quo   <= {r_quo[WIDTH-2:0], w_q_bit};
                    r_count <= r_count + 1'b1;
                    if (r_count == CNT_W'(WIDTH-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o   = r_busy;
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;
endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_div_sequencer : randomized self-checking bench for div_sequencer  |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_div_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] last_res = '0;

    div_sequencer_if #(.WIDTH(32)) dif ();

    div_sequencer #(.WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bit 32 flags a single-cycle special case; bits 31:0 are the architectural result.
    function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        r;
        logic               sp;
        sa = a;
        sb = b;
        sp = 1'b0;
        if (b == 32'd0) begin
            sp = 1'b1;
            r  = op[1] ? a : 32'hFFFF_FFFF;
        end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            sp = 1'b1;
            r  = op[1] ? 32'd0 : 32'h8000_0000;
        end else if (op[0]) begin
            r = op[1] ? (a % b) : (a / b);
        end else begin
            r = op[1] ? $unsigned(sa % sb) : $unsigned(sa / sb);
        end
        return {sp, r};
    endfunction

    task automatic scramble();
        dif.funct3_i = 3'($urandom());
        dif.a_i      = $urandom();
        dif.b_i      = $urandom();
    endtask

    // Caller sits just after a rising edge; returns just after the edge that shows done_o.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke);
        logic [32:0] e;
        int          n;
        bit          seen_busy;
        bit          got;
        e = ref_model(op, a, b);
        dif.start_i  = 1'b1;
        dif.funct3_i = {1'($urandom()), op};
        dif.a_i      = a;
        dif.b_i      = b;
        @(posedge clk); #1;
        dif.start_i = 1'b0;
        scramble();
        n = 0;
        seen_busy = dif.busy_o;
        got = dif.done_o;
        while (!got && n < 100) begin
            dif.start_i = (poke && n == 5);
            scramble();
            @(posedge clk); #1;
            n++;
            seen_busy |= dif.busy_o;
            got = dif.done_o;
        end
        dif.start_i = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", 32'(n), e[32] ? 32'd0 : 32'd34);
        check("busy_seen", {31'd0, seen_busy}, {31'd0, ~e[32]});
        check("busy_at_done", {31'd0, dif.busy_o}, 32'd0);
        check("result", dif.result_o, e[31:0]);
        last_res = e[31:0];
    endtask

    task automatic gap_check();
        @(posedge clk); #1;
        check("done_pulse", {31'd0, dif.done_o}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        dif.start_i  = 1'b0;
        dif.flush_i  = 1'b0;
        dif.funct3_i = '0;
        dif.a_i      = '0;
        dif.b_i      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, dif.busy_o}, 32'd0);
        check("rst_done", {31'd0, dif.done_o}, 32'd0);
        check("rst_result", dif.result_o, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(2'b01, 32'd100, 32'd7, 1'b0);
        check("divu_100_7", dif.result_o, 32'd14);
        gap_check();
        do_op(2'b11, 32'd100, 32'd7, 1'b0);
        check("remu_100_7", dif.result_o, 32'd2);
        gap_check();
        do_op(2'b00, 32'hFFFF_FFEC, 32'd3, 1'b0);
        check("div_m20_3", dif.result_o, 32'hFFFF_FFFA);
        gap_check();
        do_op(2'b10, 32'hFFFF_FFEC, 32'd3, 1'b0);
        check("rem_m20_3", dif.result_o, 32'hFFFF_FFFE);
        gap_check();
        do_op(2'b01, 32'd5, 32'd0, 1'b0);
        check("divu_by0", dif.result_o, 32'hFFFF_FFFF);
        gap_check();
        do_op(2'b10, 32'hFFFF_FFF7, 32'd0, 1'b0);
        check("rem_by0", dif.result_o, 32'hFFFF_FFF7);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf", dif.result_o, 32'h8000_0000);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("rem_ovf", dif.result_o, 32'd0);
        gap_check();

        // Flush while iterating with count at 10, plus a competing start request.
        dif.start_i  = 1'b1;
        dif.funct3_i = 3'b001;
        dif.a_i      = 32'd1000;
        dif.b_i      = 32'd7;
        @(posedge clk); #1;
        dif.start_i = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("busy_before_flush", {31'd0, dif.busy_o}, 32'd1);
        dif.flush_i = 1'b1;
        dif.start_i = 1'b1;
        @(posedge clk); #1;
        dif.flush_i = 1'b0;
        dif.start_i = 1'b0;
        check("flush_busy", {31'd0, dif.busy_o}, 32'd0);
        check("flush_result", dif.result_o, last_res);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen += int'(dif.done_o) + int'(dif.busy_o);
        end
        check("flush_quiet", 32'(seen), 32'd0);

        // Flush beats a simultaneous special-case start from IDLE.
        dif.flush_i  = 1'b1;
        dif.start_i  = 1'b1;
        dif.funct3_i = 3'b001;
        dif.b_i      = 32'd0;
        @(posedge clk); #1;
        dif.flush_i = 1'b0;
        dif.start_i = 1'b0;
        check("flush_start_done", {31'd0, dif.done_o}, 32'd0);
        check("flush_start_result", dif.result_o, last_res);
        do_op(2'b01, 32'd9, 32'd3, 1'b0);
        check("divu_9_3", dif.result_o, 32'd3);

        // Back-to-back with a start pulse during busy that must be ignored.
        do_op(2'b01, 32'd6, 32'd3, 1'b1);
        check("divu_6_3", dif.result_o, 32'd2);
        do_op(2'b11, 32'd7, 32'd4, 1'b1);
        check("remu_7_4", dif.result_o, 32'd3);
        gap_check();

        // Reset in the middle of an operation discards it.
        dif.start_i  = 1'b1;
        dif.funct3_i = 3'b000;
        dif.a_i      = 32'd77;
        dif.b_i      = 32'd5;
        @(posedge clk); #1;
        dif.start_i = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", {31'd0, dif.busy_o}, 32'd0);
        check("midrst_result", dif.result_o, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            seen += int'(dif.done_o);
        end
        check("midrst_quiet", 32'(seen), 32'd0);
        last_res = '0;

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom();
            b  = $urandom();
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
                3: a = 32'h8000_0000;
                4: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op(op, a, b, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) gap_check();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
